// File: rtl/rock_spawner.sv
// Rock position generator for the sprite renderer: picks a pseudo-random lane,
// drops the rock one speed step per frame, and respawns after a frame delay.
module rock_spawner #(
    parameter logic [9:0] LANE0_X     = 10'd213,
    parameter logic [9:0] LANE1_X     = 10'd320,
    parameter logic [9:0] LANE2_X     = 10'd427,
    parameter logic [9:0] SCREEN_H    = 10'd480,
    parameter logic [9:0] SPAWN_Y     = 10'd0,
    parameter logic [7:0] SPAWN_DELAY = 8'd60,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic [3:0] speed,
    input  logic       hit,
    output logic [9:0] rock_x_center,
    output logic [9:0] rock_y_top,
    output logic       rock_active,
    output logic       despawn_pulse
);

    localparam int unsigned POS_W = 10;
    localparam int unsigned SUM_W = POS_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_FALL = 2'd2;

    logic [1:0]       state, state_n;
    logic [7:0]       delay_cnt, delay_cnt_n;
    logic [7:0]       lfsr, lfsr_n;
    logic [POS_W-1:0] x_n, y_n;
    logic             active_n, despawn_n;
    logic             lfsr_fb;
    logic [POS_W-1:0] lane_x;
    logic [SUM_W-1:0] fall_sum;
    logic             off_screen;

    // x^8 + x^6 + x^5 + x^4 + 1, free-running every clock
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    // Code 3 folds onto the outer lanes so all three lanes stay reachable
    always_comb begin
        lane_x = LANE1_X;
        case (lfsr[1:0])
            2'd0:    lane_x = LANE0_X;
            2'd1:    lane_x = LANE1_X;
            2'd2:    lane_x = LANE2_X;
            default: lane_x = lfsr[2] ? LANE2_X : LANE0_X;
        endcase
    end

    // One extra bit so y + speed past 1023 still compares as off-screen
    assign fall_sum   = {1'b0, rock_y_top} + SUM_W'(speed);
    assign off_screen = (fall_sum >= {1'b0, SCREEN_H});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            rock_x_center <= LANE1_X;
            rock_y_top    <= SPAWN_Y;
            rock_active   <= 1'b0;
            despawn_pulse <= 1'b0;
            delay_cnt     <= 8'd0;
            lfsr          <= LFSR_SEED;
        end else begin
            state         <= state_n;
            rock_x_center <= x_n;
            rock_y_top    <= y_n;
            rock_active   <= active_n;
            despawn_pulse <= despawn_n;
            delay_cnt     <= delay_cnt_n;
            lfsr          <= lfsr_n;
        end
    end

    // Next-state: enable low beats hit, hit beats frame_tick
    always_comb begin
        state_n     = state;
        x_n         = rock_x_center;
        y_n         = rock_y_top;
        active_n    = rock_active;
        despawn_n   = 1'b0;
        delay_cnt_n = delay_cnt;
        lfsr_n      = {lfsr[6:0], lfsr_fb};

        if (!enable) begin
            state_n  = ST_IDLE;
            active_n = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    active_n    = 1'b0;
                    delay_cnt_n = SPAWN_DELAY;
                    state_n     = ST_WAIT;
                end
                ST_WAIT: begin
                    active_n = 1'b0;
                    if (frame_tick) begin
                        if (delay_cnt == 8'd0) begin
                            x_n      = lane_x;
                            y_n      = SPAWN_Y;
                            active_n = 1'b1;
                            state_n  = ST_FALL;
                        end else begin
                            delay_cnt_n = delay_cnt - 8'd1;
                        end
                    end
                end
                ST_FALL: begin
                    if (hit) begin
                        active_n    = 1'b0;
                        delay_cnt_n = SPAWN_DELAY;
                        state_n     = ST_WAIT;
                    end else if (frame_tick) begin
                        if (off_screen) begin
                            active_n    = 1'b0;
                            despawn_n   = 1'b1;
                            delay_cnt_n = SPAWN_DELAY;
                            state_n     = ST_WAIT;
                        end else begin
                            y_n = fall_sum[POS_W-1:0];
                        end
                    end
                end
                default: begin
                    active_n = 1'b0;
                    state_n  = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rock_spawner.sv
// Scenario bench for rock_spawner: expected outputs are queued as stimulus is
// driven and popped once the clock edge has produced the DUT response.
module tb_rock_spawner;

    localparam logic [9:0] L0 = 10'd213;
    localparam logic [9:0] L1 = 10'd320;
    localparam logic [9:0] L2 = 10'd427;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] speed = 4'd0;
    logic       hit = 1'b0;
    logic [9:0] rock_x_center;
    logic [9:0] rock_y_top;
    logic       rock_active;
    logic       despawn_pulse;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       act;
        logic       dp;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         n_checks = 0;
    int         n_pass = 0;
    logic [9:0] cur_x;
    logic [9:0] lx;
    logic [7:0] m_lfsr;

    always #5 clk = ~clk;

    rock_spawner #(.SPAWN_DELAY(8'd2)) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .enable        (enable),
        .speed         (speed),
        .hit           (hit),
        .rock_x_center (rock_x_center),
        .rock_y_top    (rock_y_top),
        .rock_active   (rock_active),
        .despawn_pulse (despawn_pulse)
    );

    // Golden LFSR: taps 8,6,5,4, seeded 0xA5, shifting every clock out of reset
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic [9:0] lane_of(input logic [7:0] l);
        case (l[1:0])
            2'd0:    return L0;
            2'd1:    return L1;
            2'd2:    return L2;
            default: return l[2] ? L2 : L0;
        endcase
    endfunction

    // Drive one clock cycle starting and ending on a falling edge
    task automatic cycle(input logic t, input logic h);
        frame_tick = t;
        hit        = h;
        @(negedge clk);
        frame_tick = 1'b0;
        hit        = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        sb.push_back('{x: L1, y: 10'd0, act: 1'b0, dp: 1'b0});
        e = sb.pop_front(); n_checks++;
        if ({rock_x_center, rock_y_top, rock_active, despawn_pulse} !== e)
            $display("FAIL reset_values: got x=%0d y=%0d act=%0b dp=%0b, expected x=%0d y=%0d act=%0b dp=%0b",
                     rock_x_center, rock_y_top, rock_active, despawn_pulse, e.x, e.y, e.act, e.dp);
        else n_pass++;
        rst = 1'b0;
        sb.push_back('{x: L1, y: 10'd0, act: 1'b0, dp: 1'b0});
        cycle(1'b1, 1'b0);
        e = sb.pop_front(); n_checks++;
        if ({rock_x_center, rock_y_top, rock_active, despawn_pulse} !== e)
            $display("FAIL idle_disabled: got x=%0d y=%0d act=%0b dp=%0b, expected x=%0d y=%0d act=%0b dp=%0b",
                     rock_x_center, rock_y_top, rock_active, despawn_pulse, e.x, e.y, e.act, e.dp);
        else n_pass++;
    endtask

    task automatic test_spawn;
        speed  = 4'd4;
        enable = 1'b1;
        cycle(1'b0, 1'b0);
        for (int t = 1; t <= 2; t++) begin
            sb.push_back('{x: L1, y: 10'd0, act: 1'b0, dp: 1'b0});
            cycle(1'b1, 1'b0);
            e = sb.pop_front(); n_checks++;
            if ({rock_x_center, rock_y_top, rock_active, despawn_pulse} !== e)
                $display("FAIL wait_tick%0d: got x=%0d y=%0d act=%0b dp=%0b, expected x=%0d y=%0d act=%0b dp=%0b",
                         t, rock_x_center, rock_y_top, rock_active, despawn_pulse, e.x, e.y, e.act, e.dp);
            else n_pass++;
        end
        lx = lane_of(m_lfsr);
        sb.push_back('{x: lx, y: 10'd0, act: 1'b1, dp: 1'b0});
        cycle(1'b1, 1'b0);
        e = sb.pop_front(); n_checks++;
        if ({rock_x_center, rock_y_top, rock_active, despawn_pulse} !== e)
            $display("FAIL spawn_3rd_tick: got x=%0d y=%0d act=%0b dp=%0b, expected x=%0d y=%0d act=%0b dp=%0b",
                     rock_x_center, rock_y_top, rock_active, despawn_pulse, e.x, e.y, e.act, e.dp);
        else n_pass++;
        cur_x = lx;
    endtask

    task automatic test_fall_despawn;
        repeat (118) cycle(1'b1, 1'b0);
        sb.push_back('{x: cur_x, y: 10'd476, act: 1'b1, dp: 1'b0});
        cycle(1'b1, 1'b0);
        e = sb.pop_front(); n_checks++;
        if ({rock_x_center, rock_y_top, rock_active, despawn_pulse} !== e)
            $display("FAIL y_after_119_ticks: got x=%0d y=%0d act=%0b dp=%0b, expected x=%0d y=%0d act=%0b dp=%0b",
                     rock_x_center, rock_y_top, rock_active, despawn_pulse, e.x, e.y, e.act, e.dp);
        else n_pass++;
        sb.push_back('{x: cur_x, y: 10'd476, act: 1'b0, dp: 1'b1});
        cycle(1'b1, 1'b0);
        e = sb.pop_front(); n_checks++;
        if ({rock_x_center, rock_y_top, rock_active, despawn_pulse} !== e)
            $display("FAIL despawn_at_480: got x=%0d y=%0d act=%0b dp=%0b, expected x=%0d y=%0d act=%0b dp=%0b",
                     rock_x_center, rock_y_top, rock_active, despawn_pulse, e.x, e.y, e.act, e.dp);
        else n_pass++;
        sb.push_back('{x: cur_x, y: 10'd476, act: 1'b0, dp: 1'b0});
        cycle(1'b0, 1'b0);
        e = sb.pop_front(); n_checks++;
        if ({rock_x_center, rock_y_top, rock_active, despawn_pulse} !== e)
            $display("FAIL despawn_one_cycle: got x=%0d y=%0d act=%0b dp=%0b, expected x=%0d y=%0d act=%0b dp=%0b",
                     rock_x_center, rock_y_top, rock_active, despawn_pulse, e.x, e.y, e.act, e.dp);
        else n_pass++;
    endtask

    task automatic test_hit;
        repeat (2) cycle(1'b1, 1'b0);
        cur_x = lane_of(m_lfsr);
        cycle(1'b1, 1'b0);
        repeat (24) cycle(1'b1, 1'b0);
        sb.push_back('{x: cur_x, y: 10'd100, act: 1'b1, dp: 1'b0});
        cycle(1'b1, 1'b0);
        e = sb.pop_front(); n_checks++;
        if ({rock_x_center, rock_y_top, rock_active, despawn_pulse} !== e)
            $display("FAIL y_at_100: got x=%0d y=%0d act=%0b dp=%0b, expected x=%0d y=%0d act=%0b dp=%0b",
                     rock_x_center, rock_y_top, rock_active, despawn_pulse, e.x, e.y, e.act, e.dp);
        else n_pass++;
        sb.push_back('{x: cur_x, y: 10'd100, act: 1'b0, dp: 1'b0});
        cycle(1'b1, 1'b1);
        e = sb.pop_front(); n_checks++;
        if ({rock_x_center, rock_y_top, rock_active, despawn_pulse} !== e)
            $display("FAIL hit_with_tick: got x=%0d y=%0d act=%0b dp=%0b, expected x=%0d y=%0d act=%0b dp=%0b",
                     rock_x_center, rock_y_top, rock_active, despawn_pulse, e.x, e.y, e.act, e.dp);
        else n_pass++;
        // hit in WAIT is ignored, so this still counts as a delay tick
        cycle(1'b1, 1'b1);
        sb.push_back('{x: cur_x, y: 10'd100, act: 1'b0, dp: 1'b0});
        cycle(1'b1, 1'b0);
        e = sb.pop_front(); n_checks++;
        if ({rock_x_center, rock_y_top, rock_active, despawn_pulse} !== e)
            $display("FAIL hit_wait_delay: got x=%0d y=%0d act=%0b dp=%0b, expected x=%0d y=%0d act=%0b dp=%0b",
                     rock_x_center, rock_y_top, rock_active, despawn_pulse, e.x, e.y, e.act, e.dp);
        else n_pass++;
        lx = lane_of(m_lfsr);
        sb.push_back('{x: lx, y: 10'd0, act: 1'b1, dp: 1'b0});
        cycle(1'b1, 1'b0);
        e = sb.pop_front(); n_checks++;
        if ({rock_x_center, rock_y_top, rock_active, despawn_pulse} !== e)
            $display("FAIL respawn_after_hit: got x=%0d y=%0d act=%0b dp=%0b, expected x=%0d y=%0d act=%0b dp=%0b",
                     rock_x_center, rock_y_top, rock_active, despawn_pulse, e.x, e.y, e.act, e.dp);
        else n_pass++;
        cur_x = lx;
    endtask

    task automatic test_enable;
        cycle(1'b1, 1'b0);
        enable = 1'b0;
        sb.push_back('{x: cur_x, y: 10'd4, act: 1'b0, dp: 1'b0});
        cycle(1'b0, 1'b0);
        e = sb.pop_front(); n_checks++;
        if ({rock_x_center, rock_y_top, rock_active, despawn_pulse} !== e)
            $display("FAIL disable_in_fall: got x=%0d y=%0d act=%0b dp=%0b, expected x=%0d y=%0d act=%0b dp=%0b",
                     rock_x_center, rock_y_top, rock_active, despawn_pulse, e.x, e.y, e.act, e.dp);
        else n_pass++;
        enable = 1'b1;
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        enable = 1'b0;
        cycle(1'b1, 1'b0);
        enable = 1'b1;
        cycle(1'b0, 1'b0);
        for (int t = 1; t <= 2; t++) begin
            sb.push_back('{x: cur_x, y: 10'd4, act: 1'b0, dp: 1'b0});
            cycle(1'b1, 1'b0);
            e = sb.pop_front(); n_checks++;
            if ({rock_x_center, rock_y_top, rock_active, despawn_pulse} !== e)
                $display("FAIL reenable_delay_tick%0d: got x=%0d y=%0d act=%0b dp=%0b, expected x=%0d y=%0d act=%0b dp=%0b",
                         t, rock_x_center, rock_y_top, rock_active, despawn_pulse, e.x, e.y, e.act, e.dp);
            else n_pass++;
        end
        lx = lane_of(m_lfsr);
        sb.push_back('{x: lx, y: 10'd0, act: 1'b1, dp: 1'b0});
        cycle(1'b1, 1'b0);
        e = sb.pop_front(); n_checks++;
        if ({rock_x_center, rock_y_top, rock_active, despawn_pulse} !== e)
            $display("FAIL reenable_spawn: got x=%0d y=%0d act=%0b dp=%0b, expected x=%0d y=%0d act=%0b dp=%0b",
                     rock_x_center, rock_y_top, rock_active, despawn_pulse, e.x, e.y, e.act, e.dp);
        else n_pass++;
        cur_x = lx;
    endtask

    task automatic test_reset_mid_fall;
        speed = 4'd10;
        repeat (19) cycle(1'b1, 1'b0);
        sb.push_back('{x: cur_x, y: 10'd200, act: 1'b1, dp: 1'b0});
        cycle(1'b1, 1'b0);
        e = sb.pop_front(); n_checks++;
        if ({rock_x_center, rock_y_top, rock_active, despawn_pulse} !== e)
            $display("FAIL y_at_200: got x=%0d y=%0d act=%0b dp=%0b, expected x=%0d y=%0d act=%0b dp=%0b",
                     rock_x_center, rock_y_top, rock_active, despawn_pulse, e.x, e.y, e.act, e.dp);
        else n_pass++;
        #1;
        rst    = 1'b1;
        enable = 1'b0;
        #1;
        sb.push_back('{x: L1, y: 10'd0, act: 1'b0, dp: 1'b0});
        e = sb.pop_front(); n_checks++;
        if ({rock_x_center, rock_y_top, rock_active, despawn_pulse} !== e)
            $display("FAIL async_reset_mid_fall: got x=%0d y=%0d act=%0b dp=%0b, expected x=%0d y=%0d act=%0b dp=%0b",
                     rock_x_center, rock_y_top, rock_active, despawn_pulse, e.x, e.y, e.act, e.dp);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lanes;
        int seen0, seen1, seen2;
        seen0 = 0; seen1 = 0; seen2 = 0;
        speed  = 4'd0;
        enable = 1'b1;
        cycle(1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b0);
            cycle(1'b1, 1'b0);
            cycle(1'b1, 1'b0);
            repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b0);
            lx = lane_of(m_lfsr);
            sb.push_back('{x: lx, y: 10'd0, act: 1'b1, dp: 1'b0});
            cycle(1'b1, 1'b0);
            e = sb.pop_front(); n_checks++;
            if ({rock_x_center, rock_y_top, rock_active, despawn_pulse} !== e)
                $display("FAIL lane_spawn%0d: got x=%0d y=%0d act=%0b dp=%0b, expected x=%0d y=%0d act=%0b dp=%0b",
                         i, rock_x_center, rock_y_top, rock_active, despawn_pulse, e.x, e.y, e.act, e.dp);
            else n_pass++;
            if (rock_x_center == L0) seen0++;
            if (rock_x_center == L1) seen1++;
            if (rock_x_center == L2) seen2++;
            if (i < 4) begin
                sb.push_back('{x: lx, y: 10'd0, act: 1'b1, dp: 1'b0});
                repeat (3) cycle(1'b1, 1'b0);
                e = sb.pop_front(); n_checks++;
                if ({rock_x_center, rock_y_top, rock_active, despawn_pulse} !== e)
                    $display("FAIL speed0_frozen%0d: got x=%0d y=%0d act=%0b dp=%0b, expected x=%0d y=%0d act=%0b dp=%0b",
                             i, rock_x_center, rock_y_top, rock_active, despawn_pulse, e.x, e.y, e.act, e.dp);
                else n_pass++;
            end
            cycle(1'b0, 1'b1);
        end
        n_checks++;
        if (seen0 == 0 || seen1 == 0 || seen2 == 0)
            $display("FAIL all_lanes_seen: got counts L0=%0d L1=%0d L2=%0d, expected each at least 1",
                     seen0, seen1, seen2);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_fall_despawn();
        test_hit();
        test_enable();
        test_reset_mid_fall();
        test_lanes();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
